pixel_frame_parser: RTL
=======================

// Module: pixel_frame_parser
// PURPOSE
// - Sits between uart_top RX output (rx_rd_data/rx_valid) and canny_edge_top pixel input.
// - Hunts for a 2-byte sync word and decodes a 4-byte width/height header.
// - Forwards exactly W*H payload bytes as pixels, tagged with sof/eol/eof and the decoded frame dims.
// - Aborts and re-hunts on a bad header or a stalled stream.
// PARAMETERS
// - DATA_W     8        byte/pixel width (= FIFO_WIDTH)
// - DIM_W      16       width/height field width
// - MAX_W      640      largest accepted frame width
// - MAX_H      480      largest accepted frame height
// - SYNC0      8'hA5    first sync byte
// - SYNC1      8'h5A    second sync byte
// - TIMEOUT    2**20    idle cycles tolerated mid-frame before abort
// PORTS
// - clk           in   1       system clock
// - rst           in   1       synchronous, active-high reset
// - in_data       in   DATA_W  byte from UART RX FIFO
// - in_valid      in   1       in_data valid this cycle (no backpressure)
// - pixel_out     out  DATA_W  payload pixel
// - pixel_valid   out  1       pixel_out valid
// - sof           out  1       with first pixel of frame
// - eol           out  1       with last pixel of each row
// - eof           out  1       with last pixel of frame
// - frame_width   out  DIM_W   decoded W, held until next header
// - frame_height  out  DIM_W   decoded H, held until next header
// - busy          out  1       high from SYNC0 accepted until eof/abort
// - hdr_err       out  1       1-cycle pulse: W or H is 0 or exceeds MAX
// - timeout_err   out  1       1-cycle pulse: TIMEOUT idle cycles after SYNC0
// BEHAVIOUR
// - Decided: one clock (clk); reset synchronous, active-high (rst).
// - Reset: state=HUNT; all outputs 0; dims 0; counters 0.
// - Header bytes are big-endian: SYNC0 SYNC1 W_hi W_lo H_hi H_lo.
// - FSM: HUNT -> GOT_S0 on SYNC0, else stay.
//   - GOT_S0 -> W_HI on SYNC1; stay on SYNC0; else HUNT.
//   - W_HI -> W_LO -> H_HI -> H_LO, one state per valid byte.
//   - H_LO: if W==0, H==0, W>MAX_W or H>MAX_H -> hdr_err pulse, HUNT.
//     Otherwise latch dims and go to PAYLOAD.
// - States advance only on in_valid; in_valid=0 holds state.
// - PAYLOAD: each in_valid byte -> pixel_out registered, pixel_valid=1 next cycle (latency 1).
//   - col counts 0..W-1 and wraps; row increments on wrap.
//   - sof when col==0 && row==0.
//   - eol when col==W-1.
//   - eof when col==W-1 && row==H-1; FSM returns to HUNT the same edge.
// - Payload bytes equal to SYNC0/SYNC1 are pixels; sync is never searched mid-payload.
// - Timeout: idle counter clears on every in_valid; counts in all states except HUNT.
//   At TIMEOUT: timeout_err pulse, busy=0, go to HUNT. No eof is emitted; a partial frame stays partial.
// - Byte on the cycle after eof is parsed in HUNT (back-to-back frames allowed).
// - rst mid-frame: immediate return to reset state; no flags are emitted.
// - Flags and pixel_valid are single-cycle, aligned with the pixel they tag.
// STRUCTURE
// - definitions_pkg adds:
//   - typedef enum logic [2:0] frame_state_t {HUNT, GOT_S0, W_HI, W_LO, H_HI, H_LO, PAYLOAD}
//   - typedef logic [DIM_W-1:0] dim_t
//   - localparams SYNC0_BYTE, SYNC1_BYTE
// - One sub-module: frame_pos_counter (col/row counters with wrap, sof/eol/eof decode).
// - All in/out registers live in pixel_frame_parser.
// TESTING
// - Frame A5 5A 00 04 00 02 + 8 bytes -> 8 pixel_valid; sof on pixel 0; eol on pixels 3 and 7; eof on 7; dims 4x2.
// - Leading junk 00 A5 A5 5A 00 02 00 02 + 4 bytes -> frame decoded 2x2; no hdr_err.
// - Header W=0x0000 or W=MAX_W+1 -> hdr_err pulse, no pixel_valid; next valid frame parses.
// - 2x2 frame with payload A5 5A A5 5A -> 4 pixels out unchanged; eof on the 4th.
// - Stall of TIMEOUT cycles after 3 of 4 pixels -> timeout_err, busy=0, no eof; next frame OK.
// - rst asserted after pixel 2 -> outputs 0 next cycle; new header parses normally.

Source files
------------

// File: rtl/pixel_frame_parser_pkg.sv
// Shared types and constants for the UART-to-pixel frame parser.
package pixel_frame_parser_pkg;

    localparam int unsigned DEF_DIM_W = 16;

    // Sync word that opens every frame header.
    localparam logic [7:0] SYNC0_BYTE = 8'hA5;
    localparam logic [7:0] SYNC1_BYTE = 8'h5A;

    // Parser states: sync hunt, four big-endian header bytes, then payload.
    typedef enum logic [2:0] {
        HUNT,
        GOT_S0,
        W_HI,
        W_LO,
        H_HI,
        H_LO,
        PAYLOAD
    } frame_state_t;

    typedef logic [DEF_DIM_W-1:0] dim_t;

endpackage

// File: rtl/frame_pos_counter.sv
// Column/row position tracker for the payload of one frame.
// Flags decode the position of the byte being accepted this cycle.
module frame_pos_counter #(
    parameter int unsigned DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic             sof_o,
    output logic             eol_o,
    output logic             eof_o
);

    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;

    assign sof_o = (col_q == '0) && (row_q == '0);
    assign eol_o = (col_q == width_i - DIM_W'(1));
    assign eof_o = eol_o && (row_q == height_i - DIM_W'(1));

    // Next position: wrap column at end of row, wrap everything at end of frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (eol_o) begin
                col_d = '0;
                row_d = eof_o ? '0 : row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/pixel_frame_parser.sv
// Byte-stream frame parser: finds the sync word, decodes a W/H header and
// forwards exactly W*H payload bytes as tagged pixels (one cycle latency).
module pixel_frame_parser
    import pixel_frame_parser_pkg::*;
#(
    parameter int unsigned        DATA_W  = 8,
    parameter int unsigned        DIM_W   = DEF_DIM_W,
    parameter int unsigned        MAX_W   = 640,
    parameter int unsigned        MAX_H   = 480,
    parameter logic [DATA_W-1:0]  SYNC0   = DATA_W'(SYNC0_BYTE),
    parameter logic [DATA_W-1:0]  SYNC1   = DATA_W'(SYNC1_BYTE),
    parameter int unsigned        TIMEOUT = 2**20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] pixel_out,
    output logic              pixel_valid,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic [DIM_W-1:0]  frame_width,
    output logic [DIM_W-1:0]  frame_height,
    output logic              busy,
    output logic              hdr_err,
    output logic              timeout_err
);

    localparam int unsigned       HDR_W     = 2 * DATA_W;
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [HDR_W-1:0]  MAX_W_HDR = HDR_W'(MAX_W);
    localparam logic [HDR_W-1:0]  MAX_H_HDR = HDR_W'(MAX_H);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    frame_state_t      state_q, state_d;
    logic [DATA_W-1:0] w_hi_q, w_hi_d;
    logic [DATA_W-1:0] w_lo_q, w_lo_d;
    logic [DATA_W-1:0] h_hi_q, h_hi_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic              eof_q, eof_d;
    logic              busy_q, busy_d;
    logic              hdr_err_q, hdr_err_d;
    logic              timeout_err_q, timeout_err_d;

    logic              px_fire;
    logic              pos_clear;
    logic              pos_sof, pos_eol, pos_eof;
    logic [HDR_W-1:0]  hdr_w, hdr_h;
    logic              hdr_bad;
    logic              timeout_hit;

    // Header fields as they stand when the final header byte is on the bus.
    assign hdr_w   = {w_hi_q, w_lo_q};
    assign hdr_h   = {h_hi_q, in_data};
    assign hdr_bad = (hdr_w == '0) || (hdr_h == '0) ||
                     (hdr_w > MAX_W_HDR) || (hdr_h > MAX_H_HDR);

    // TIMEOUT-th consecutive idle cycle outside HUNT.
    assign timeout_hit = (state_q != HUNT) && !in_valid && (idle_q == IDLE_LAST);

    assign pos_clear = (state_q != PAYLOAD);

    frame_pos_counter #(
        .DIM_W (DIM_W)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (pos_clear),
        .advance_i (px_fire),
        .width_i   (width_q),
        .height_i  (height_q),
        .sof_o     (pos_sof),
        .eol_o     (pos_eol),
        .eof_o     (pos_eof)
    );

    // Next-state and output decode; every byte advances at most one state.
    always_comb begin
        state_d       = state_q;
        w_hi_d        = w_hi_q;
        w_lo_d        = w_lo_q;
        h_hi_d        = h_hi_q;
        width_d       = width_q;
        height_d      = height_q;
        px_fire       = 1'b0;
        hdr_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        idle_d        = (in_valid || state_q == HUNT) ? '0 : idle_q + IDLE_W'(1);

        case (state_q)
            HUNT: begin
                if (in_valid && in_data == SYNC0) state_d = GOT_S0;
            end
            GOT_S0: begin
                if (in_valid) begin
                    if (in_data == SYNC1)      state_d = W_HI;
                    else if (in_data == SYNC0) state_d = GOT_S0;
                    else                       state_d = HUNT;
                end
            end
            W_HI: begin
                if (in_valid) begin
                    w_hi_d  = in_data;
                    state_d = W_LO;
                end
            end
            W_LO: begin
                if (in_valid) begin
                    w_lo_d  = in_data;
                    state_d = H_HI;
                end
            end
            H_HI: begin
                if (in_valid) begin
                    h_hi_d  = in_data;
                    state_d = H_LO;
                end
            end
            H_LO: begin
                if (in_valid) begin
                    if (hdr_bad) begin
                        hdr_err_d = 1'b1;
                        state_d   = HUNT;
                    end else begin
                        width_d  = DIM_W'(hdr_w);
                        height_d = DIM_W'(hdr_h);
                        state_d  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (in_valid) begin
                    px_fire = 1'b1;
                    if (pos_eof) state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        if (timeout_hit) begin
            state_d       = HUNT;
            timeout_err_d = 1'b1;
        end

        pixel_d       = px_fire ? in_data : pixel_q;
        pixel_valid_d = px_fire;
        sof_d         = px_fire && pos_sof;
        eol_d         = px_fire && pos_eol;
        eof_d         = px_fire && pos_eof;
        busy_d        = (state_d != HUNT);
    end

    // State, header capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            w_hi_q        <= '0;
            w_lo_q        <= '0;
            h_hi_q        <= '0;
            width_q       <= '0;
            height_q      <= '0;
            idle_q        <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            busy_q        <= 1'b0;
            hdr_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_hi_q        <= w_hi_d;
            w_lo_q        <= w_lo_d;
            h_hi_q        <= h_hi_d;
            width_q       <= width_d;
            height_q      <= height_d;
            idle_q        <= idle_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            eof_q         <= eof_d;
            busy_q        <= busy_d;
            hdr_err_q     <= hdr_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pixel_out    = pixel_q;
    assign pixel_valid  = pixel_valid_q;
    assign sof          = sof_q;
    assign eol          = eol_q;
    assign eof          = eof_q;
    assign frame_width  = width_q;
    assign frame_height = height_q;
    assign busy         = busy_q;
    assign hdr_err      = hdr_err_q;
    assign timeout_err  = timeout_err_q;

endmodule
